cache_nway: RTL and testbench

//  Parametrised N-way set-associative write-back, write-allocate cache between the pipeline
//  (word port) and the 4-word block memory port. Drop-in successor to the fixed 2-way cache for
//  I- and D-side. Adds configurable sets/ways, invalid-first + per-set round-robin replacement,
//  and hit/miss performance counters.

---
 rtl/cache_pkg.sv | 26 ++
 rtl/cache_victim_sel.sv | 19 +
 rtl/cache_nway.sv | 202 ++++++++++++++++++++
 tb/tb_cache_nway.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared types and field-width helpers for the N-way set-associative cache.
package cache_pkg;
    localparam int BLK_WORDS = 4;
    localparam int ADDR_W    = 30;
    localparam int WORD_W    = 32;
    localparam int BLK_W     = BLK_WORDS * WORD_W;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WRITE_BACK = 2'd1,
        ALLOCATE   = 2'd2,
        REFILL     = 2'd3
    } cache_state_e;

    function automatic int idx_width(input int num_sets);
        return $clog2(num_sets);
    endfunction

    function automatic int way_width(input int num_ways);
        return (num_ways > 1) ? $clog2(num_ways) : 1;
    endfunction

    function automatic int tag_width(input int num_sets);
        return ADDR_W - 2 - $clog2(num_sets);
    endfunction
endpackage

// File: rtl/cache_victim_sel.sv
// Replacement choice for one set: lowest-index invalid way, otherwise the round-robin pointer.
module cache_victim_sel
    import cache_pkg::*;
#(
    parameter int NUM_WAYS = 2,
    parameter int WAY_W    = 1
)(
    input  logic [NUM_WAYS-1:0] i_valid,
    input  logic [WAY_W-1:0]    i_rr_ptr,
    output logic [WAY_W-1:0]    o_victim
);
    // Scan downwards so the lowest invalid way is the last one written.
    always_comb begin
        o_victim = i_rr_ptr;
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (!i_valid[w]) o_victim = WAY_W'(w);
        end
    end
endmodule

// File: rtl/cache_nway.sv
// N-way set-associative write-back, write-allocate cache between a word port and a 4-word block memory.
module cache_nway
    import cache_pkg::*;
#(
    parameter int NUM_SETS = 4,
    parameter int NUM_WAYS = 2,
    parameter int CNT_W    = 32
)(
    input  logic              clk,
    input  logic              proc_reset,
    input  logic              proc_read,
    input  logic              proc_write,
    input  logic [ADDR_W-1:0] proc_addr,
    input  logic [31:0]       proc_wdata,
    output logic              proc_stall,
    output logic [31:0]       proc_rdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic [27:0]       mem_addr,
    output logic [BLK_W-1:0]  mem_wdata,
    input  logic [BLK_W-1:0]  mem_rdata,
    input  logic              mem_ready,
    output logic [CNT_W-1:0]  hit_count,
    output logic [CNT_W-1:0]  miss_count
);
    localparam int IDX_W     = idx_width(NUM_SETS);
    localparam int WAY_W     = way_width(NUM_WAYS);
    localparam int TAG_W     = tag_width(NUM_SETS);
    localparam int NUM_LINES = NUM_SETS * NUM_WAYS;
    localparam int LINE_W    = $clog2(NUM_LINES);

    function automatic logic [LINE_W-1:0] line_of(input logic [IDX_W-1:0] idx, input logic [WAY_W-1:0] way);
        return LINE_W'(int'(idx) * NUM_WAYS + int'(way));
    endfunction

    cache_state_e         r_state, w_state_nx;
    logic [NUM_LINES-1:0] r_valid, w_valid_nx, r_dirty, w_dirty_nx;
    logic [TAG_W-1:0]     r_tag [NUM_LINES];
    logic [TAG_W-1:0]     w_tag_nx [NUM_LINES];
    logic [BLK_W-1:0]     r_data [NUM_LINES];
    logic [BLK_W-1:0]     w_data_nx [NUM_LINES];
    logic [WAY_W-1:0]     r_rr [NUM_SETS];
    logic [WAY_W-1:0]     w_rr_nx [NUM_SETS];
    logic [WAY_W-1:0]     r_victim, w_victim_nx;
    logic [BLK_W-1:0]     r_refill, w_refill_nx;
    logic                 r_from_refill;
    logic [CNT_W-1:0]     r_hits, w_hits_nx, r_misses, w_misses_nx;

    logic [IDX_W-1:0]     w_idx;
    logic [TAG_W-1:0]     w_tag;
    logic [1:0]           w_word;
    logic                 w_req, w_hit;
    logic [WAY_W-1:0]     w_hit_way, w_vsel, w_vic_way;
    logic [LINE_W-1:0]    w_hit_line, w_vic_line;
    logic [NUM_WAYS-1:0]  w_set_valid;

    assign w_idx  = proc_addr[IDX_W+1:2];
    assign w_tag  = proc_addr[ADDR_W-1:IDX_W+2];
    assign w_word = proc_addr[1:0];
    assign w_req  = proc_read | proc_write;

    always_comb begin
        w_hit       = 1'b0;
        w_hit_way   = '0;
        w_set_valid = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            w_set_valid[w] = r_valid[line_of(w_idx, WAY_W'(w))];
            if (r_valid[line_of(w_idx, WAY_W'(w))] && r_tag[line_of(w_idx, WAY_W'(w))] == w_tag) begin
                w_hit     = 1'b1;
                w_hit_way = WAY_W'(w);
            end
        end
    end

    cache_victim_sel #(.NUM_WAYS(NUM_WAYS), .WAY_W(WAY_W)) u_victim_sel (
        .i_valid  (w_set_valid),
        .i_rr_ptr (r_rr[w_idx]),
        .o_victim (w_vsel)
    );

    // The victim is chosen live in IDLE and frozen for the rest of the miss.
    assign w_vic_way  = (r_state == IDLE) ? w_vsel : r_victim;
    assign w_hit_line = line_of(w_idx, w_hit_way);
    assign w_vic_line = line_of(w_idx, w_vic_way);
    assign proc_rdata = r_data[w_hit_line][{w_word, 5'd0} +: 32];
    assign hit_count  = r_hits;
    assign miss_count = r_misses;

    always_comb begin
        w_state_nx = r_state;
        proc_stall = w_req;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        case (r_state)
            IDLE: begin
                proc_stall = w_req & ~w_hit;
                // A held request during reset must not reach the memory port.
                if (w_req && !w_hit) begin
                    if (r_dirty[w_vic_line]) begin
                        w_state_nx = WRITE_BACK;
                        if (!proc_reset) begin
                            mem_write = 1'b1;
                            mem_addr  = {r_tag[w_vic_line], w_idx};
                            mem_wdata = r_data[w_vic_line];
                        end
                    end else begin
                        w_state_nx = ALLOCATE;
                        if (!proc_reset) begin
                            mem_read = 1'b1;
                            mem_addr = proc_addr[ADDR_W-1:2];
                        end
                    end
                end
            end
            WRITE_BACK: begin
                mem_write = 1'b1;
                mem_addr  = {r_tag[w_vic_line], w_idx};
                mem_wdata = r_data[w_vic_line];
                if (mem_ready) w_state_nx = ALLOCATE;
            end
            ALLOCATE: begin
                mem_read = 1'b1;
                mem_addr = proc_addr[ADDR_W-1:2];
                if (mem_ready) w_state_nx = REFILL;
            end
            REFILL: w_state_nx = IDLE;
            default: w_state_nx = IDLE;
        endcase
    end

    always_comb begin
        w_valid_nx  = r_valid;
        w_dirty_nx  = r_dirty;
        w_tag_nx    = r_tag;
        w_data_nx   = r_data;
        w_rr_nx     = r_rr;
        w_victim_nx = r_victim;
        w_refill_nx = r_refill;
        w_hits_nx   = r_hits;
        w_misses_nx = r_misses;
        case (r_state)
            IDLE: begin
                if (w_req && w_hit) begin
                    if (proc_write) begin
                        w_data_nx[w_hit_line][{w_word, 5'd0} +: 32] = proc_wdata;
                        w_dirty_nx[w_hit_line] = 1'b1;
                    end
                    // The replay hit right after a refill belongs to the miss.
                    if (!r_from_refill) w_hits_nx = r_hits + CNT_W'(1);
                end else if (w_req) begin
                    w_victim_nx = w_vsel;
                    w_misses_nx = r_misses + CNT_W'(1);
                end
            end
            ALLOCATE: begin
                if (mem_ready) w_refill_nx = mem_rdata;
            end
            REFILL: begin
                if (r_valid[w_vic_line]) begin
                    w_rr_nx[w_idx] = (r_rr[w_idx] == WAY_W'(NUM_WAYS - 1)) ? '0 : r_rr[w_idx] + WAY_W'(1);
                end
                w_data_nx[w_vic_line]  = r_refill;
                w_tag_nx[w_vic_line]   = w_tag;
                w_valid_nx[w_vic_line] = 1'b1;
                w_dirty_nx[w_vic_line] = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (proc_reset) begin
            r_state       <= IDLE;
            r_valid       <= '0;
            r_dirty       <= '0;
            r_victim      <= '0;
            r_refill      <= '0;
            r_from_refill <= 1'b0;
            r_hits        <= '0;
            r_misses      <= '0;
            for (int l = 0; l < NUM_LINES; l++) begin
                r_tag[l]  <= '0;
                r_data[l] <= '0;
            end
            for (int s = 0; s < NUM_SETS; s++) r_rr[s] <= '0;
        end else begin
            r_state       <= w_state_nx;
            r_valid       <= w_valid_nx;
            r_dirty       <= w_dirty_nx;
            r_tag         <= w_tag_nx;
            r_data        <= w_data_nx;
            r_rr          <= w_rr_nx;
            r_victim      <= w_victim_nx;
            r_refill      <= w_refill_nx;
            r_from_refill <= (r_state == REFILL);
            r_hits        <= w_hits_nx;
            r_misses      <= w_misses_nx;
        end
    end
endmodule

// File: tb/tb_cache_nway.sv
// Randomized self-checking bench for cache_nway (4 sets, 4 ways) against a set/way reference model.
module tb_cache_nway;
    localparam int NS = 4;
    localparam int NW = 4;

    logic         clk = 1'b0;
    logic         proc_reset, proc_read, proc_write;
    logic [29:0]  proc_addr;
    logic [31:0]  proc_wdata, proc_rdata;
    logic         proc_stall, mem_read, mem_write, mem_ready;
    logic [27:0]  mem_addr;
    logic [127:0] mem_wdata, mem_rdata;
    logic [31:0]  hit_count, miss_count;

    always #5 clk = ~clk;

    cache_nway #(.NUM_SETS(NS), .NUM_WAYS(NW), .CNT_W(32)) dut (
        .clk        (clk),
        .proc_reset (proc_reset),
        .proc_read  (proc_read),
        .proc_write (proc_write),
        .proc_addr  (proc_addr),
        .proc_wdata (proc_wdata),
        .proc_stall (proc_stall),
        .proc_rdata (proc_rdata),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: contents per set/way plus a backing block store.
    logic         m_valid [NS][NW];
    logic         m_dirty [NS][NW];
    logic [25:0]  m_tag   [NS][NW];
    logic [31:0]  m_word  [NS][NW][4];
    int           m_rr    [NS];
    int unsigned  m_hits, m_misses;
    logic [127:0] backing [logic [27:0]];

    function automatic logic [127:0] mem_block(input logic [27:0] ba);
        logic [127:0] b;
        if (backing.exists(ba)) return backing[ba];
        for (int i = 0; i < 4; i++) b[i*32 +: 32] = {2'(i), 2'b10, ba};
        return b;
    endfunction

    task automatic model_reset();
        for (int s = 0; s < NS; s++) begin
            m_rr[s] = 0;
            for (int w = 0; w < NW; w++) begin
                m_valid[s][w] = 1'b0;
                m_dirty[s][w] = 1'b0;
                m_tag[s][w]   = '0;
                for (int i = 0; i < 4; i++) m_word[s][w][i] = '0;
            end
        end
        m_hits   = 0;
        m_misses = 0;
    endtask

    task automatic reset_dut();
        proc_reset = 1'b1;
        proc_read  = 1'b0;
        proc_write = 1'b0;
        mem_ready  = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check_val("rst_stall", proc_stall, 0);
        check_val("rst_mem_rw", {mem_read, mem_write}, 0);
        check_val("rst_mem_addr", mem_addr, 0);
        check_val("rst_mem_wdata", mem_wdata, 0);
        check_val("rst_hits", hit_count, 0);
        check_val("rst_misses", miss_count, 0);
        @(posedge clk); #1;
        proc_reset = 1'b0;
        model_reset();
    endtask

    // dw/dr: the mem_write/mem_read cycle on which mem_ready is pulsed (first high cycle is the IDLE miss cycle).
    task automatic access(input logic rd, input logic wr, input logic [29:0] addr, input logic [31:0] wd,
                          input int dw, input int dr);
        int s, wy, vic, wi, stall_cyc, nw, nr, exp_stall;
        logic [25:0] tg;
        logic exp_wb, done;
        logic [27:0] wb_addr;
        logic [127:0] wb_data, blk;
        logic [31:0] exp_rd;
        s  = int'(addr[3:2]);
        tg = addr[29:4];
        wi = int'(addr[1:0]);
        wy = -1;
        for (int w = 0; w < NW; w++) if (m_valid[s][w] && m_tag[s][w] == tg) wy = w;
        exp_wb = 1'b0; wb_addr = '0; wb_data = '0; exp_stall = 0; blk = '0;
        if (wy < 0) begin
            vic = -1;
            for (int w = NW - 1; w >= 0; w--) if (!m_valid[s][w]) vic = w;
            if (vic < 0) begin
                vic = m_rr[s];
                m_rr[s] = (m_rr[s] + 1) % NW;
            end
            if (m_valid[s][vic] && m_dirty[s][vic]) begin
                exp_wb  = 1'b1;
                wb_addr = {m_tag[s][vic], 2'(s)};
                for (int i = 0; i < 4; i++) wb_data[i*32 +: 32] = m_word[s][vic][i];
                backing[wb_addr] = wb_data;
            end
            blk = mem_block(addr[29:2]);
            m_valid[s][vic] = 1'b1;
            m_dirty[s][vic] = 1'b0;
            m_tag[s][vic]   = tg;
            for (int i = 0; i < 4; i++) m_word[s][vic][i] = blk[i*32 +: 32];
            m_misses++;
            exp_stall = exp_wb ? dw + dr + 1 : dr + 1;
            wy = vic;
        end else begin
            m_hits++;
        end
        if (wr) begin
            m_word[s][wy][wi] = wd;
            m_dirty[s][wy]    = 1'b1;
        end
        exp_rd = m_word[s][wy][wi];

        proc_read = rd; proc_write = wr; proc_addr = addr; proc_wdata = wd;
        done = 1'b0; stall_cyc = 0; nw = 0; nr = 0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            mem_rdata = {$urandom(), $urandom(), $urandom(), $urandom()};
            check_val("mem_rw_exclusive", mem_read & mem_write, 0);
            if (!mem_write) check_val("mem_wdata_zero", mem_wdata, 0);
            if (!proc_stall) begin
                done = 1'b1;
                check_val("done_mem_idle", {mem_read, mem_write}, 0);
                if (!wr) check_val("rdata", proc_rdata, exp_rd);
            end else begin
                if (stall_cyc == 0) check_val("wb_taken", mem_write, exp_wb);
                stall_cyc++;
                if (mem_write) begin
                    nw++;
                    check_val("wb_addr", mem_addr, wb_addr);
                    check_val("wb_data", mem_wdata, wb_data);
                    if (nw == dw) mem_ready = 1'b1;
                end else if (mem_read) begin
                    nr++;
                    check_val("rd_addr", mem_addr, addr[29:2]);
                    if (nr == dr) begin
                        mem_ready = 1'b1;
                        mem_rdata = blk;
                    end
                end
            end
            @(posedge clk); #1;
            mem_ready = 1'b0;
        end
        proc_read = 1'b0; proc_write = 1'b0;
        check_val("complete", done, 1);
        check_val("stall_cycles", stall_cyc, exp_stall);
        check_val("hit_count", hit_count, m_hits);
        check_val("miss_count", miss_count, m_misses);
    endtask

    task automatic idle_check(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            mem_ready = (i == 0);
            mem_rdata = {$urandom(), $urandom(), $urandom(), $urandom()};
            check_val("idle_stall", proc_stall, 0);
            check_val("idle_mem_rw", {mem_read, mem_write}, 0);
            @(posedge clk); #1;
            mem_ready = 1'b0;
        end
        check_val("idle_hits", hit_count, m_hits);
        check_val("idle_misses", miss_count, m_misses);
    endtask

    task automatic reset_mid_alloc(input logic [29:0] addr);
        proc_addr = addr;
        proc_read = 1'b1;
        @(negedge clk);
        check_val("t5_idle_mem_read", mem_read, 1);
        @(posedge clk); #1;
        @(negedge clk);
        check_val("t5_alloc_mem_read", mem_read, 1);
        proc_reset = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check_val("t5_rst_mem_rw", {mem_read, mem_write}, 0);
        check_val("t5_rst_mem_addr", mem_addr, 0);
        check_val("t5_rst_stall", proc_stall, 1);
        check_val("t5_rst_hits", hit_count, 0);
        check_val("t5_rst_misses", miss_count, 0);
        @(posedge clk); #1;
        proc_reset = 1'b0;
        proc_read  = 1'b0;
        model_reset();
    endtask

    initial begin
        logic [25:0] tg;
        int r;
        proc_reset = 1'b1; proc_read = 1'b0; proc_write = 1'b0;
        proc_addr = '0; proc_wdata = '0; mem_ready = 1'b0; mem_rdata = '0;
        reset_dut();

        // 1: first read miss, 4-cycle ALLOCATE response
        backing[28'h0000004] = {32'hDDDD_DDDD, 32'hCCCC_CCCC, 32'hBBBB_BBBB, 32'hAAAA_AAAA};
        access(1'b1, 1'b0, 30'h0000_0010, 32'h0, 2, 4);
        // 2: fill set 0 and evict clean way 0
        for (int t = 2; t <= 5; t++) access(1'b1, 1'b0, {26'(t), 2'b00, 2'b00}, 32'h0, 2, 2);
        // 3: dirty way 0 word 2, then cycle round-robin back to it
        access(1'b0, 1'b1, {26'd5, 2'b00, 2'b10}, 32'hCAFE_0001, 2, 2);
        for (int t = 6; t <= 9; t++) access(1'b1, 1'b0, {26'(t), 2'b00, 2'b01}, 32'h0, 3, 2);
        // 4: write misses into set 1 until the victim is dirty
        for (int t = 1; t <= 5; t++) access(1'b0, 1'b1, {26'(t), 2'b01, 2'b11}, 32'h5000_0000 + t, 3, 3);
        access(1'b1, 1'b0, {26'd5, 2'b01, 2'b11}, 32'h0, 2, 2);
        // 6: simultaneous read and write on a hit
        access(1'b1, 1'b1, {26'd5, 2'b01, 2'b00}, 32'h1234_5678, 2, 2);
        access(1'b1, 1'b0, {26'd5, 2'b01, 2'b00}, 32'h0, 2, 2);
        idle_check(3);
        // 5: reset while in ALLOCATE, then the same address misses again
        reset_mid_alloc({26'h3FF_FF01, 2'b10, 2'b01});
        access(1'b1, 1'b0, {26'h3FF_FF01, 2'b10, 2'b01}, 32'h0, 2, 3);

        for (int i = 0; i < 300; i++) begin
            tg = 26'($urandom_range(7, 0));
            if (tg[0]) tg[25:24] = 2'b11;
            r = int'($urandom_range(3, 0));
            access(r != 1, (r == 1) || (r == 2), {tg, 2'($urandom_range(3, 0)), 2'($urandom_range(3, 0))},
                   $urandom(), int'($urandom_range(4, 2)), int'($urandom_range(4, 2)));
            if (i % 50 == 0) idle_check(2);
        end
        idle_check(2);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
